// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    // addi x0,x0,0: what a flushed pipeline register carries downstream
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    function automatic logic is_load_use(
        input logic             de_m2r,
        input logic             de_regwrt,
        input logic [REG_W-1:0] de_rd,
        input logic             use_rs1,
        input logic [REG_W-1:0] rs1,
        input logic             use_rs2,
        input logic [REG_W-1:0] rs2
    );
        return de_m2r && de_regwrt && (de_rd != REG_ZERO) &&
               ((use_rs1 && (rs1 == de_rd)) || (use_rs2 && (rs2 == de_rd)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-to-hazard-unit signal bundle; slave is the hazard unit, master the pipeline.
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 32
);
    import hazard_stall_unit_pkg::*;

    logic [REG_W-1:0] fd_rs1;
    logic [REG_W-1:0] fd_rs2;
    logic             fd_use_rs1;
    logic             fd_use_rs2;
    logic [REG_W-1:0] de_rd;
    logic             de_regwrt;
    logic             de_m2r;
    logic             br_taken;
    logic             em_mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             fd_en;
    logic             fd_flush;
    logic             de_en;
    logic             de_flush;
    logic             em_en;
    logic             mw_en;
    logic             mw_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  fd_rs1, fd_rs2, fd_use_rs1, fd_use_rs2, de_rd, de_regwrt, de_m2r,
               br_taken, em_mem_req, mem_ready,
        output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush,
               mem_err, stall_cnt
    );

    modport master (
        output fd_rs1, fd_rs2, fd_use_rs1, fd_use_rs2, de_rd, de_regwrt, de_m2r,
               br_taken, em_mem_req, mem_ready,
        input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush,
               mem_err, stall_cnt
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module hazard_stall_unit_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard controller: load-use bubbles, taken-branch squash and data-memory wait freeze
// with timeout; pipeline enables/flushes are combinational from state and inputs.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    hazard_stall_unit_if.slave hz
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e         r_state;
    hz_state_e         w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_mem_err;
    logic              w_mem_err_nxt;

    logic w_lu;
    logic w_mh_raw;
    logic w_timeout;
    logic w_mh;
    logic w_pc_en, w_fd_en, w_fd_flush, w_de_en, w_de_flush, w_em_en, w_mw_en, w_mw_flush;
    logic [CNT_W-1:0] w_stall_cnt;

    assign w_lu = is_load_use(hz.de_m2r, hz.de_regwrt, hz.de_rd,
                              hz.fd_use_rs1, hz.fd_rs1, hz.fd_use_rs2, hz.fd_rs2);
    assign w_mh_raw  = hz.em_mem_req && !hz.mem_ready;
    // The last allowed wait cycle is itself the forced release: the hold is masked here.
    assign w_timeout = (r_state == MEM_WAIT) && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_mh      = w_mh_raw && !w_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err || (w_timeout && w_mh_raw);
        w_pc_en        = 1'b1;
        w_fd_en        = 1'b1;
        w_fd_flush     = 1'b0;
        w_de_en        = 1'b1;
        w_de_flush     = 1'b0;
        w_em_en        = 1'b1;
        w_mw_en        = 1'b1;
        w_mw_flush     = 1'b0;

        unique case (r_state)
            RUN: begin
                if (w_mh) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (w_mh) begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase

        if (i_rst) begin
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_de_en    = 1'b0;
            w_em_en    = 1'b0;
            w_mw_en    = 1'b0;
            w_fd_flush = 1'b1;
            w_de_flush = 1'b1;
            w_mw_flush = 1'b1;
        end else if (w_mh) begin
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_de_en    = 1'b0;
            w_em_en    = 1'b0;
            w_mw_flush = 1'b1;
        end else if (hz.br_taken) begin
            w_fd_flush = 1'b1;
            w_de_flush = 1'b1;
        end else if (w_lu) begin
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_de_flush = 1'b1;
        end
    end

    hazard_stall_unit_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (1'b0),
        .i_inc (!w_pc_en && !i_rst),
        .o_cnt (w_stall_cnt)
    );

    assign hz.pc_en     = w_pc_en;
    assign hz.fd_en     = w_fd_en;
    assign hz.fd_flush  = w_fd_flush;
    assign hz.de_en     = w_de_en;
    assign hz.de_flush  = w_de_flush;
    assign hz.em_en     = w_em_en;
    assign hz.mw_en     = w_mw_en;
    assign hz.mw_flush  = w_mw_flush;
    assign hz.mem_err   = r_mem_err;
    assign hz.stall_cnt = w_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with MEM_TIMEOUT=4, CNT_W=4.
module tb_hazard_stall_unit;

    localparam int unsigned MT = 4;
    localparam int unsigned CW = 4;

    // {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush}
    localparam logic [7:0] V_NORM = 8'b1101_0110;
    localparam logic [7:0] V_RST  = 8'b0010_1001;
    localparam logic [7:0] V_LU   = 8'b0001_1110;
    localparam logic [7:0] V_BR   = 8'b1111_1110;
    localparam logic [7:0] V_FRZ  = 8'b0000_0011;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_stall_unit_if #(.CNT_W(CW)) hz ();

    hazard_stall_unit #(
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctl();
        return {hz.pc_en, hz.fd_en, hz.fd_flush, hz.de_en, hz.de_flush,
                hz.em_en, hz.mw_en, hz.mw_flush};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle inputs/outputs mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.fd_rs1 = '0; hz.fd_rs2 = '0; hz.fd_use_rs1 = 1'b0; hz.fd_use_rs2 = 1'b0;
        hz.de_rd = '0; hz.de_regwrt = 1'b0; hz.de_m2r = 1'b0; hz.br_taken = 1'b0;
        hz.em_mem_req = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        hz.de_m2r = 1'b1; hz.de_regwrt = 1'b1; hz.de_rd = 5'd5;
        hz.fd_rs1 = 5'd5; hz.fd_use_rs1 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        #2;
        check_eq("rst_ctl", 32'(ctl()), 32'(V_RST));
        tick();
        tick();
        rst = 1'b0;
        #2;
        check_eq("post_rst_ctl", 32'(ctl()), 32'(V_NORM));
        check_eq("post_rst_cnt", 32'(hz.stall_cnt), 32'd0);
        check_eq("post_rst_err", 32'(hz.mem_err), 32'd0);

        // load-use: one bubble, then DE holds the bubble
        set_lu(); #1;
        check_eq("lu_ctl", 32'(ctl()), 32'(V_LU));
        tick();
        hz.de_m2r = 1'b0; hz.de_regwrt = 1'b0; #1;
        check_eq("lu_after_ctl", 32'(ctl()), 32'(V_NORM));
        check_eq("lu_cnt", 32'(hz.stall_cnt), 32'd1);

        // x0 never creates a load-use; unused source never matches
        idle(); set_lu(); hz.de_rd = 5'd0; hz.fd_rs1 = 5'd0; #1;
        check_eq("x0_ctl", 32'(ctl()), 32'(V_NORM));
        idle(); set_lu(); hz.fd_use_rs1 = 1'b0; #1;
        check_eq("norse1_ctl", 32'(ctl()), 32'(V_NORM));
        hz.fd_rs2 = 5'd5; hz.fd_use_rs2 = 1'b1; #1;
        check_eq("lu_rs2_ctl", 32'(ctl()), 32'(V_LU));
        tick();
        check_eq("lu_rs2_cnt", 32'(hz.stall_cnt), 32'd2);

        // branch beats load-use
        idle(); set_lu(); hz.br_taken = 1'b1; #1;
        check_eq("br_lu_ctl", 32'(ctl()), 32'(V_BR));
        tick();
        check_eq("br_cnt", 32'(hz.stall_cnt), 32'd2);

        // memory wait of three cycles, branch+LU ignored while frozen
        idle(); hz.em_mem_req = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin set_lu(); hz.br_taken = 1'b1; end
            #1;
            check_eq($sformatf("mw_frz%0d", i), 32'(ctl()), 32'(V_FRZ));
            tick();
        end
        check_eq("mw_cnt", 32'(hz.stall_cnt), 32'd5);
        hz.mem_ready = 1'b1; #1;
        check_eq("mw_rel_ctl", 32'(ctl()), 32'(V_BR));
        tick();
        idle(); hz.em_mem_req = 1'b1; hz.mem_ready = 1'b1; #1;
        check_eq("mw_ready_now", 32'(ctl()), 32'(V_NORM));
        tick();
        check_eq("mw_cnt2", 32'(hz.stall_cnt), 32'd5);
        check_eq("mw_err", 32'(hz.mem_err), 32'd0);

        // timeout: four freeze cycles, then forced release with sticky error
        idle(); hz.em_mem_req = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("to_frz%0d", i), 32'(ctl()), 32'(V_FRZ));
            check_eq($sformatf("to_err%0d", i), 32'(hz.mem_err), 32'd0);
            tick();
        end
        check_eq("to_rel_ctl", 32'(ctl()), 32'(V_NORM));
        tick();
        hz.em_mem_req = 1'b0; #1;
        check_eq("to_err_set", 32'(hz.mem_err), 32'd1);
        check_eq("to_cnt", 32'(hz.stall_cnt), 32'd9);
        tick();
        tick();
        check_eq("to_err_sticky", 32'(hz.mem_err), 32'd1);

        // saturation at 15 under a held load-use
        set_lu();
        for (int i = 0; i < 10; i++) tick();
        check_eq("sat_cnt", 32'(hz.stall_cnt), 32'd15);

        // reset while waiting on memory
        idle(); hz.em_mem_req = 1'b1; #1;
        tick();
        tick();
        rst = 1'b1; #1;
        check_eq("rst_mid_ctl", 32'(ctl()), 32'(V_RST));
        tick();
        rst = 1'b0; #1;
        check_eq("rst_mid_cnt", 32'(hz.stall_cnt), 32'd0);
        check_eq("rst_mid_err", 32'(hz.mem_err), 32'd0);
        // wait counter restarted: full four freezes before the forced release
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rst_to_frz%0d", i), 32'(ctl()), 32'(V_FRZ));
            tick();
        end
        check_eq("rst_to_rel", 32'(ctl()), 32'(V_NORM));
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
